sparse_expand: RTL
==================

Name: sparse_expand

Overview:
- Receive side of the sparsified counter stream: accepts compacted (index, value) pairs of surviving counters and re-expands them into a dense, in-order frame of NUM_COUNTERS counters.
- Every index absent from the pair stream is emitted as zero.
- Sits between the sketch-transfer link and the reconstruction/query logic, which consumes one dense counter per beat.

Parameters:
- NUM_COUNTERS, 64: dense frame length (2..2^IDX_W).
- IDX_W, 6: index width; must satisfy 2^IDX_W >= NUM_COUNTERS.
- THRESHOLD, 20: sparsification threshold; a legal nonzero value is > THRESHOLD.
- STEP, 5: quantisation step; a legal nonzero value is a multiple of STEP.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- In_Valid  in  1  pair valid.
- In_Ready  out  1  pair accepted when In_Valid && In_Ready.
- In_Index  in  IDX_W  dense position of the pair.
- In_Value  in  32  sparsified counter value.
- In_Last  in  1  final pair of the frame.
- In_Empty  in  1  with In_Last: terminator only, no data (In_Index/In_Value ignored).
- Out_Valid  out  1  dense beat valid.
- Out_Ready  in  1  downstream accepts beat.
- Out_Counter  out  32  reconstructed counter.
- Out_Index  out  IDX_W  position of beat (0..NUM_COUNTERS-1).
- Out_Last  out  1  beat at NUM_COUNTERS-1.
- Frame_Done  out  1  one-cycle pulse the cycle after the Out_Last beat is accepted.
- Err_Order  out  1  sticky: pair dropped (index out of order, duplicate, or >= NUM_COUNTERS).
- Err_Value  out  1  sticky: accepted nonzero value <= THRESHOLD or not a multiple of STEP.

Behaviour:
- Reset (async, active-high): all outputs 0, pos=0, pair buffer empty, state IDLE, sticky flags cleared. Reset mid-frame discards the frame; the next frame restarts at pos 0.
- Internal storage: one-entry pair buffer (idx, val, last, empty) and registered output stage.
- In_Ready = buffer empty && state != FLUSH.
- The output register loads when !Out_Valid || Out_Ready.
- States:
  - IDLE: pos=0, wait for first pair -> EXPAND.
  - EXPAND, at each output load slot:
    - buffer empty -> Out_Valid=0 (stall; a zero cannot be emitted until the next index is known).
    - buffer empty flag set -> go FLUSH.
    - idx == pos -> emit val, free buffer, pos++. If last && pos < NUM_COUNTERS-1 -> FLUSH.
    - idx > pos -> emit 0, pos++, keep buffer.
    - idx < pos or idx >= NUM_COUNTERS -> drop pair, set Err_Order, no beat this slot. If last, go FLUSH.
  - FLUSH: emit 0 per slot until pos=NUM_COUNTERS-1.
- Frame end: the beat at pos=NUM_COUNTERS-1 carries Out_Last=1; when it is accepted, pulse Frame_Done, pos=0, state -> IDLE.
- Pairs remaining after the Out_Last beat belong to the next frame.
- Stall rule: Out_Counter/Out_Index/Out_Last hold stable while Out_Valid && !Out_Ready.
- Latency: an accepted pair whose index equals pos appears on Out_* 2 cycles after acceptance.
- Throughput: 1 beat/cycle during zero-fill and FLUSH; back-to-back consecutive indices sustain 1 pair per 2 cycles.
- Err_Value check is applied to the raw In_Value before any offset. The value is still emitted.

Optional Feature:
- MIDPOINT_RECON_EN defined: each emitted nonzero counter = In_Value + STEP/2 (integer; +2 with defaults), wrapping modulo 2^32. This gives an unbiased estimate of the pre-quantisation counter. Zero-fill beats remain 0.
- Not defined: nonzero counters are emitted verbatim. No adder is present.

Test Plan:
- Pairs (2,25),(5,40,last), Out_Ready=1 -> 64 beats: idx2=25, idx5=40, all others 0; Out_Last only at idx63; one Frame_Done pulse. With MIDPOINT_RECON_EN, idx2=27 and idx5=42.
- Single pair In_Last=1, In_Empty=1 -> 64 zero beats, Out_Last at 63, Frame_Done.
- Pairs (10,30),(7,50),(10,35),(20,60,last) -> (7,50) and (10,35) dropped, Err_Order=1 sticky; idx10=30, idx20=60, rest 0.
- Pair (3,17) then (4,33,last) -> Err_Value=1; beats idx3=17, idx4=33 still emitted.
- Out_Ready toggled pseudo-randomly during the first test -> identical beat sequence; outputs stable during every stall cycle.
- Reset pulsed at pos=30 mid-frame, then the first test is replayed -> flags cleared; new frame starts at idx0 and completes correctly.

Source files
------------

// File: rtl/sparse_expand.sv
// sparse_expand: rebuilds a dense, in-order frame of NUM_COUNTERS counters from (index, value) pairs.
// Optional feature macro MIDPOINT_RECON_EN: adds STEP/2 to every nonzero emitted counter.
module sparse_expand #(
    parameter int NUM_COUNTERS = 64,
    parameter int IDX_W        = 6,
    parameter int THRESHOLD    = 20,
    parameter int STEP         = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IDX_W-1:0] In_Index,
    input  logic [31:0]      In_Value,
    input  logic             In_Last,
    input  logic             In_Empty,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [31:0]      Out_Counter,
    output logic [IDX_W-1:0] Out_Index,
    output logic             Out_Last,
    output logic             Frame_Done,
    output logic             Err_Order,
    output logic             Err_Value
);
    typedef enum logic [1:0] {IDLE, EXPAND, FLUSH} state_t;

    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_COUNTERS);
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NUM_COUNTERS - 1);
    localparam logic [31:0]      THRESH_V = 32'(THRESHOLD);
    localparam logic [31:0]      STEP_V   = 32'(STEP);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] pos_reg, pos_next;
    logic             buf_valid_reg, buf_valid_next;
    logic [IDX_W-1:0] buf_idx_reg, buf_idx_next;
    logic [31:0]      buf_val_reg, buf_val_next;
    logic             buf_last_reg, buf_last_next;
    logic             buf_empty_reg, buf_empty_next;
    logic             out_valid_reg, out_valid_next;
    logic [31:0]      out_counter_reg, out_counter_next;
    logic [IDX_W-1:0] out_index_reg, out_index_next;
    logic             out_last_reg, out_last_next;
    logic             frame_done_reg, frame_done_next;
    logic             err_order_reg, err_order_next;
    logic             err_value_reg, err_value_next;

    logic        in_ready, accept, load, last_pending, at_end, idx_in_range, value_bad;
    logic        emit;
    logic [31:0] emit_val, recon;

`ifdef MIDPOINT_RECON_EN
    assign recon = (buf_val_reg == 32'd0) ? 32'd0 : buf_val_reg + 32'(STEP / 2);
`else
    assign recon = buf_val_reg;
`endif

    assign in_ready     = !buf_valid_reg && (state_reg != FLUSH);
    assign accept       = In_Valid && in_ready;
    assign load         = !out_valid_reg || Out_Ready;
    // The final beat of a frame sits in the output register until accepted.
    assign last_pending = out_valid_reg && out_last_reg;
    assign at_end       = (pos_reg == LAST_POS);
    assign idx_in_range = ({1'b0, buf_idx_reg} < NUM_EXT);
    assign value_bad    = (In_Value != 32'd0) &&
                          ((In_Value <= THRESH_V) || ((In_Value % STEP_V) != 32'd0));

    always_comb begin
        state_next       = state_reg;
        pos_next         = pos_reg;
        buf_valid_next   = buf_valid_reg;
        buf_idx_next     = buf_idx_reg;
        buf_val_next     = buf_val_reg;
        buf_last_next    = buf_last_reg;
        buf_empty_next   = buf_empty_reg;
        out_valid_next   = out_valid_reg;
        out_counter_next = out_counter_reg;
        out_index_next   = out_index_reg;
        out_last_next    = out_last_reg;
        frame_done_next  = 1'b0;
        err_order_next   = err_order_reg;
        err_value_next   = err_value_reg;
        emit             = 1'b0;
        emit_val         = 32'd0;

        if (load) begin
            if (last_pending) begin
                out_valid_next  = 1'b0;
                out_last_next   = 1'b0;
                frame_done_next = 1'b1;
                pos_next        = '0;
                state_next      = IDLE;
            end else begin
                out_valid_next = 1'b0;
                case (state_reg)
                    EXPAND: begin
                        // An empty buffer stalls: the gap length is unknown until the next index arrives.
                        if (buf_valid_reg) begin
                            if (buf_empty_reg) begin
                                buf_valid_next = 1'b0;
                                state_next     = FLUSH;
                            end else if (buf_idx_reg == pos_reg) begin
                                emit           = 1'b1;
                                emit_val       = recon;
                                buf_valid_next = 1'b0;
                                if (buf_last_reg && !at_end)
                                    state_next = FLUSH;
                            end else if (idx_in_range && (buf_idx_reg > pos_reg)) begin
                                emit = 1'b1;
                            end else begin
                                buf_valid_next = 1'b0;
                                err_order_next = 1'b1;
                                if (buf_last_reg)
                                    state_next = FLUSH;
                            end
                        end
                    end
                    FLUSH:   emit = 1'b1;
                    default: ;
                endcase
                if (emit) begin
                    out_valid_next   = 1'b1;
                    out_counter_next = emit_val;
                    out_index_next   = pos_reg;
                    out_last_next    = at_end;
                    if (!at_end)
                        pos_next = pos_reg + 1'b1;
                end
            end
        end

        if ((state_reg == IDLE) && (accept || buf_valid_reg))
            state_next = EXPAND;

        if (accept) begin
            buf_valid_next = 1'b1;
            buf_idx_next   = In_Index;
            buf_val_next   = In_Value;
            buf_last_next  = In_Last;
            buf_empty_next = In_Empty;
            if (!In_Empty && value_bad)
                err_value_next = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IDLE;
            pos_reg         <= '0;
            buf_valid_reg   <= 1'b0;
            buf_idx_reg     <= '0;
            buf_val_reg     <= '0;
            buf_last_reg    <= 1'b0;
            buf_empty_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_counter_reg <= '0;
            out_index_reg   <= '0;
            out_last_reg    <= 1'b0;
            frame_done_reg  <= 1'b0;
            err_order_reg   <= 1'b0;
            err_value_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pos_reg         <= pos_next;
            buf_valid_reg   <= buf_valid_next;
            buf_idx_reg     <= buf_idx_next;
            buf_val_reg     <= buf_val_next;
            buf_last_reg    <= buf_last_next;
            buf_empty_reg   <= buf_empty_next;
            out_valid_reg   <= out_valid_next;
            out_counter_reg <= out_counter_next;
            out_index_reg   <= out_index_next;
            out_last_reg    <= out_last_next;
            frame_done_reg  <= frame_done_next;
            err_order_reg   <= err_order_next;
            err_value_reg   <= err_value_next;
        end
    end

    assign In_Ready    = in_ready;
    assign Out_Valid   = out_valid_reg;
    assign Out_Counter = out_counter_reg;
    assign Out_Index   = out_index_reg;
    assign Out_Last    = out_last_reg;
    assign Frame_Done  = frame_done_reg;
    assign Err_Order   = err_order_reg;
    assign Err_Value   = err_value_reg;
endmodule
